// File: rtl/seq_mul_add_if.sv
// Handshake/operand bundle for seq_mul_add: start/operands in, busy/done/result out.
interface seq_mul_add_if #(
  parameter int DATAWIDTH = 64
);
  logic                 start;
  logic [DATAWIDTH-1:0] q;
  logic [DATAWIDTH-1:0] b;
  logic [DATAWIDTH-1:0] r;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] z;
  logic                 ovf;

  modport master (
    output start, q, b, r,
    input  busy, done, z, ovf
  );

  modport slave (
    input  start, q, b, r,
    output busy, done, z, ovf
  );
endinterface

// File: rtl/seq_mul_add.sv
// Multi-cycle unsigned z = q*b + r (radix-2 shift-add with remainder preload).
// Rebuilds a dividend from a quotient/divisor/remainder triple; ovf flags a carry past DATAWIDTH.
module seq_mul_add #(
  parameter int DATAWIDTH = 64
) (
  input logic          Clk,
  input logic          Rst,
  seq_mul_add_if.slave bus
);
  localparam int CW = $clog2(DATAWIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 r_state;
  logic [2*DATAWIDTH:0]   r_acc;
  logic [2*DATAWIDTH-1:0] r_mcand;
  logic [DATAWIDTH-1:0]   r_mplier;
  logic [CW-1:0]          r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [DATAWIDTH-1:0]   r_z;
  logic                   r_ovf;

  logic [2*DATAWIDTH:0]   w_acc_next;
  logic                   w_last;

  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + {1'b0, r_mcand};
    end
    w_last = (r_cnt == CW'(DATAWIDTH - 1));
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_z      <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_acc    <= {{(DATAWIDTH + 1){1'b0}}, bus.r};
            r_mcand  <= {{DATAWIDTH{1'b0}}, bus.b};
            r_mplier <= bus.q;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state  <= IDLE;
          end
        end
        RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          // Result taken from the final iteration's sum so done lands one cycle after the last RUN cycle.
          if (w_last) begin
            r_z     <= w_acc_next[DATAWIDTH-1:0];
            r_ovf   <= |w_acc_next[2*DATAWIDTH:DATAWIDTH];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.z    = r_z;
  assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_seq_mul_add.sv
// Directed and round-trip checks for seq_mul_add at DATAWIDTH=8 and DATAWIDTH=64.
module tb_seq_mul_add;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_excl   = 0;

  always #5 clk = ~clk;

  seq_mul_add_if #(.DATAWIDTH(8))  if8 ();
  seq_mul_add_if #(.DATAWIDTH(64)) if64 ();

  seq_mul_add #(.DATAWIDTH(8))  u_dut8  (.Clk(clk), .Rst(rst), .bus(if8));
  seq_mul_add #(.DATAWIDTH(64)) u_dut64 (.Clk(clk), .Rst(rst), .bus(if64));

  // q, b, r, expected z, expected ovf
  logic [7:0] vq [0:8] = '{8'd255, 8'd255, 8'd0,   8'd0,  8'd200, 8'd16, 8'd15, 8'd255, 8'd123};
  logic [7:0] vb [0:8] = '{8'd255, 8'd1,   8'd0,   8'd77, 8'd2,   8'd16, 8'd17, 8'd255, 8'd0};
  logic [7:0] vr [0:8] = '{8'd0,   8'd1,   8'd255, 8'd5,  8'd100, 8'd0,  8'd0,  8'd255, 8'd42};
  logic [7:0] vz [0:8] = '{8'h01,  8'h00,  8'hFF,  8'h05, 8'hF4,  8'h00, 8'hFF, 8'h00,  8'h2A};
  logic       vo [0:8] = '{1'b1,   1'b1,   1'b0,   1'b0,  1'b1,   1'b1,  1'b0,  1'b1,   1'b0};

  always @(negedge clk) begin
    if ((if8.done && if8.busy) || (if64.done && if64.busy)) n_excl++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle (lat = cycles after accept).
  task automatic job8(input logic [7:0] q, input logic [7:0] b, input logic [7:0] r, input int rp,
                      output logic [7:0] z, output logic ovf, output int lat, output int bc);
    if8.start = 1'b1; if8.q = q; if8.b = b; if8.r = r;
    @(negedge clk);
    lat = -1; bc = 0; z = '0; ovf = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (rp != 0 && c == rp) begin
        if8.start = 1'b1; if8.q = 8'hAA; if8.b = 8'h55; if8.r = 8'h11;
      end else begin
        if8.start = 1'b0;
      end
      if (if8.done) begin
        lat = c; z = if8.z; ovf = if8.ovf;
        break;
      end
      if (if8.busy) bc++;
      @(negedge clk);
    end
  endtask

  task automatic job64(input logic [63:0] q, input logic [63:0] b, input logic [63:0] r,
                       output logic [63:0] z, output logic ovf, output int lat);
    if64.start = 1'b1; if64.q = q; if64.b = b; if64.r = r;
    @(negedge clk);
    lat = -1; z = '0; ovf = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if64.start = 1'b0;
      if (if64.done) begin
        lat = c; z = if64.z; ovf = if64.ovf;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0]  z8;
    logic [63:0] z64, a, bb;
    logic        o;
    int          lat, bc;

    if8.start = 1'b0;  if8.q = '0;  if8.b = '0;  if8.r = '0;
    if64.start = 1'b0; if64.q = '0; if64.b = '0; if64.r = '0;
    repeat (3) @(negedge clk);
    check("rst_busy8", if8.busy, 0);
    check("rst_done8", if8.done, 0);
    check("rst_z8", if8.z, 0);
    check("rst_ovf8", if8.ovf, 0);
    check("rst_busy64", if64.busy, 0);
    check("rst_z64", if64.z, 0);
    rst = 1'b0;
    @(negedge clk);

    job8(8'd7, 8'd9, 8'd4, 0, z8, o, lat, bc);
    check("t1_z", z8, 8'h43);
    check("t1_ovf", o, 0);
    check("t1_lat", lat, 9);
    check("t1_busy_cycles", bc, 8);
    repeat (5) @(negedge clk);
    check("t1_z_hold", if8.z, 8'h43);
    check("t1_idle_busy", if8.busy, 0);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      job8(vq[i], vb[i], vr[i], 0, z8, o, lat, bc);
      check($sformatf("vec%0d_z", i), z8, vz[i]);
      check($sformatf("vec%0d_ovf", i), o, vo[i]);
      check($sformatf("vec%0d_lat", i), lat, 9);
    end

    // Abort: start in cycle 0, reset in cycle 4, restart in cycle 6.
    @(negedge clk);
    if8.start = 1'b1; if8.q = 8'd5; if8.b = 8'd6; if8.r = 8'd7;
    @(negedge clk);
    if8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", if8.busy, 0);
    check("rst_mid_done", if8.done, 0);
    check("rst_mid_z", if8.z, 0);
    check("rst_mid_ovf", if8.ovf, 0);
    @(negedge clk);
    check("rst_mid_nodone", if8.done, 0);
    job8(8'd12, 8'd11, 8'd3, 0, z8, o, lat, bc);
    check("t3_z", z8, 8'h87);
    check("t3_ovf", o, 0);
    check("t3_lat", lat, 9);

    @(negedge clk);
    job8(8'd3, 8'd5, 8'd1, 3, z8, o, lat, bc);
    check("t4_repulse_z", z8, 8'd16);
    check("t4_repulse_lat", lat, 9);

    @(negedge clk);
    job8(8'd3, 8'd5, 8'd1, 0, z8, o, lat, bc);
    check("t4_b2b_first_z", z8, 8'd16);
    job8(8'd20, 8'd13, 8'd9, 0, z8, o, lat, bc);
    check("t4_b2b_second_z", z8, 8'h0D);
    check("t4_b2b_second_ovf", o, 1);
    check("t4_b2b_second_lat", lat, 9);

    @(negedge clk);
    job64(64'hFFFF_FFFF, 64'h1_0000_0001, 64'd0, z64, o, lat);
    check("t5_z", z64, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t5_ovf", o, 0);
    check("t5_lat", lat, 65);

    @(negedge clk);
    job64('1, '1, '1, z64, o, lat);
    check("t5_max_z", z64, 64'd0);
    check("t5_max_ovf", o, 1);

    for (int n = 0; n < 200; n++) begin
      a  = {$urandom, $urandom};
      bb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (bb == 0) bb = 64'd1;
      @(negedge clk);
      job64(a / bb, bb, a % bb, z64, o, lat);
      check("rt_z", z64, a);
      check("rt_ovf", o, 0);
    end

    check("done_busy_excl", n_excl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
